// File: rtl/raccoon_ctrl_if.sv
// raccoon_ctrl_if: frame pacing, buttons, car positions and game outputs
// exchanged between the game-logic stage and its environment.
interface raccoon_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [9:0] carX_1;
  logic [9:0] carY_1;
  logic [9:0] carX_2;
  logic [9:0] carY_2;
  logic [9:0] carX_3;
  logic [9:0] carY_3;
  logic [9:0] raccoonX;
  logic [9:0] raccoonY;
  logic [1:0] lives;
  logic [7:0] score;
  logic       dead;
  logic       game_over;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right,
    output carX_1, carY_1, carX_2, carY_2, carX_3, carY_3,
    input  raccoonX, raccoonY, lives, score, dead, game_over
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right,
    input  carX_1, carY_1, carX_2, carY_2, carX_3, carY_3,
    output raccoonX, raccoonY, lives, score, dead, game_over
  );
endinterface

// File: rtl/raccoon_ctrl.sv
// raccoon_ctrl: owns the raccoon grid position, frame-paced movement,
// collision against three cars, lives/score and the play/dying/game-over
// state machine. Every state change happens on a frame_tick cycle only.
module raccoon_ctrl #(
  parameter int GRID_W        = 32,
  parameter int GRID_H        = 32,
  parameter int COLS          = 20,
  parameter int ROWS          = 15,
  parameter int CAR_W         = 64,
  parameter int CAR_H         = 32,
  parameter int LIVES         = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int MOVE_COOLDOWN = 8
) (
  input logic           clk,
  input logic           reset,
  raccoon_ctrl_if.slave bus
);

  localparam int              DW         = $clog2(DEATH_FRAMES + 1);
  localparam logic [9:0]      START_X    = 10'((COLS / 2 - 1) * GRID_W);
  localparam logic [9:0]      START_Y    = 10'((ROWS - 1) * GRID_H);
  localparam logic [9:0]      MAX_X      = 10'((COLS - 1) * GRID_W);
  localparam logic [9:0]      MAX_Y      = 10'((ROWS - 1) * GRID_H);
  localparam logic [9:0]      STEP_X     = 10'(GRID_W);
  localparam logic [9:0]      STEP_Y     = 10'(GRID_H);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
  localparam logic [3:0]      CD_LOAD    = 4'(MOVE_COOLDOWN);
  localparam logic [DW-1:0]   DEATH_LOAD = DW'(DEATH_FRAMES);
  localparam logic [DW-1:0]   DEATH_ZERO = {DW{1'b0}};

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_DYING = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Overlap test of the raccoon cell against one car; widened to 11 bits so
  // the right/bottom edges never wrap.
  function automatic logic car_hit(input logic [9:0] rx, input logic [9:0] ry,
                                   input logic [9:0] cx, input logic [9:0] cy);
    logic [10:0] rx_w;
    logic [10:0] ry_w;
    logic [10:0] cx_w;
    logic [10:0] cy_w;
    rx_w = {1'b0, rx};
    ry_w = {1'b0, ry};
    cx_w = {1'b0, cx};
    cy_w = {1'b0, cy};
    car_hit = (rx_w < cx_w + 11'(CAR_W)) && (cx_w < rx_w + 11'(GRID_W)) &&
              (ry_w < cy_w + 11'(CAR_H)) && (cy_w < ry_w + 11'(GRID_H));
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [9:0]    x_r;
  logic [9:0]    y_r;
  logic [1:0]    lives_r;
  logic [7:0]    score_r;
  logic [3:0]    cooldown_r;
  logic [DW-1:0] death_cnt_r;
  logic          dead_r;
  logic          game_over_r;

  logic [9:0]    x_nxt_s;
  logic [9:0]    y_nxt_s;
  logic [1:0]    lives_nxt_s;
  logic [7:0]    score_nxt_s;
  logic [3:0]    cooldown_nxt_s;
  logic [DW-1:0] death_cnt_nxt_s;
  logic          dead_nxt_s;
  logic          game_over_nxt_s;

  logic          hit_s;
  logic          any_btn_s;
  logic [3:0]    cd_dec_s;
  logic [DW-1:0] death_dec_s;
  logic          move_ok_s;
  logic [9:0]    tgt_x_s;
  logic [9:0]    tgt_y_s;

  assign hit_s = car_hit(x_r, y_r, bus.carX_1, bus.carY_1) ||
                 car_hit(x_r, y_r, bus.carX_2, bus.carY_2) ||
                 car_hit(x_r, y_r, bus.carX_3, bus.carY_3);

  assign any_btn_s   = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
  // The cooldown check looks at the already-decremented value, so a move
  // is accepted every MOVE_COOLDOWN ticks while a button is held.
  assign cd_dec_s    = (cooldown_r != 4'd0) ? (cooldown_r - 4'd1) : 4'd0;
  assign death_dec_s = (death_cnt_r != DEATH_ZERO) ? (death_cnt_r - DW'(1)) : DEATH_ZERO;

  // Pick the highest-priority button and check its target cell is on the grid.
  always_comb begin
    tgt_x_s   = x_r;
    tgt_y_s   = y_r;
    move_ok_s = 1'b0;
    if (bus.btn_up) begin
      if (y_r >= STEP_Y) begin
        tgt_y_s   = y_r - STEP_Y;
        move_ok_s = 1'b1;
      end else begin
        move_ok_s = 1'b0;
      end
    end else if (bus.btn_down) begin
      if (y_r < MAX_Y) begin
        tgt_y_s   = y_r + STEP_Y;
        move_ok_s = 1'b1;
      end else begin
        move_ok_s = 1'b0;
      end
    end else if (bus.btn_left) begin
      if (x_r >= STEP_X) begin
        tgt_x_s   = x_r - STEP_X;
        move_ok_s = 1'b1;
      end else begin
        move_ok_s = 1'b0;
      end
    end else if (bus.btn_right) begin
      if (x_r < MAX_X) begin
        tgt_x_s   = x_r + STEP_X;
        move_ok_s = 1'b1;
      end else begin
        move_ok_s = 1'b0;
      end
    end else begin
      move_ok_s = 1'b0;
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_PLAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: hit starts dying, end of dying resumes or ends the game.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.frame_tick) begin
      case (state_r)
        ST_PLAY: begin
          if (hit_s) begin
            state_nxt_s = ST_DYING;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_DYING: begin
          if (death_dec_s == DEATH_ZERO) begin
            if (lives_r == 2'd0) begin
              state_nxt_s = ST_OVER;
            end else begin
              state_nxt_s = ST_PLAY;
            end
          end else begin
            state_nxt_s = ST_DYING;
          end
        end
        ST_OVER: begin
          if (any_btn_s) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_OVER;
          end
        end
        default: state_nxt_s = ST_PLAY;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Status flags decoded from the next state so they register alongside it.
  always_comb begin
    dead_nxt_s      = 1'b0;
    game_over_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_PLAY: begin
        dead_nxt_s      = 1'b0;
        game_over_nxt_s = 1'b0;
      end
      ST_DYING: begin
        dead_nxt_s      = 1'b1;
        game_over_nxt_s = 1'b0;
      end
      ST_OVER: begin
        dead_nxt_s      = 1'b0;
        game_over_nxt_s = 1'b1;
      end
      default: begin
        dead_nxt_s      = 1'b0;
        game_over_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath update: position, lives, score, cooldown and death counter.
  always_comb begin
    x_nxt_s         = x_r;
    y_nxt_s         = y_r;
    lives_nxt_s     = lives_r;
    score_nxt_s     = score_r;
    cooldown_nxt_s  = cooldown_r;
    death_cnt_nxt_s = death_cnt_r;
    if (bus.frame_tick) begin
      cooldown_nxt_s = cd_dec_s;
      case (state_r)
        ST_PLAY: begin
          if (hit_s) begin
            lives_nxt_s     = lives_r - 2'd1;
            death_cnt_nxt_s = DEATH_LOAD;
          end else if ((cd_dec_s == 4'd0) && any_btn_s && move_ok_s) begin
            cooldown_nxt_s = CD_LOAD;
            if (tgt_y_s == 10'd0) begin
              // Reaching the far side scores and sends the raccoon home.
              x_nxt_s     = START_X;
              y_nxt_s     = START_Y;
              score_nxt_s = (score_r == 8'd255) ? 8'd255 : (score_r + 8'd1);
            end else begin
              x_nxt_s = tgt_x_s;
              y_nxt_s = tgt_y_s;
            end
          end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
          end
        end
        ST_DYING: begin
          death_cnt_nxt_s = death_dec_s;
          if ((death_dec_s == DEATH_ZERO) && (lives_r != 2'd0)) begin
            x_nxt_s        = START_X;
            y_nxt_s        = START_Y;
            cooldown_nxt_s = 4'd0;
          end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
          end
        end
        ST_OVER: begin
          if (any_btn_s) begin
            // Restart press loads the cooldown so it cannot also move.
            lives_nxt_s    = LIVES_INIT;
            score_nxt_s    = 8'd0;
            x_nxt_s        = START_X;
            y_nxt_s        = START_Y;
            cooldown_nxt_s = CD_LOAD;
          end else begin
            lives_nxt_s = lives_r;
          end
        end
        default: begin
          x_nxt_s = x_r;
        end
      endcase
    end else begin
      cooldown_nxt_s = cooldown_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r         <= START_X;
      y_r         <= START_Y;
      lives_r     <= LIVES_INIT;
      score_r     <= 8'd0;
      cooldown_r  <= 4'd0;
      death_cnt_r <= DEATH_ZERO;
      dead_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      x_r         <= x_nxt_s;
      y_r         <= y_nxt_s;
      lives_r     <= lives_nxt_s;
      score_r     <= score_nxt_s;
      cooldown_r  <= cooldown_nxt_s;
      death_cnt_r <= death_cnt_nxt_s;
      dead_r      <= dead_nxt_s;
      game_over_r <= game_over_nxt_s;
    end
  end

  assign bus.raccoonX  = x_r;
  assign bus.raccoonY  = y_r;
  assign bus.lives     = lives_r;
  assign bus.score     = score_r;
  assign bus.dead      = dead_r;
  assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_raccoon_ctrl.sv
// tb_raccoon_ctrl: table-driven vectors, hand sequences for the multi-frame
// corners, and a randomized run against a grid-level game model.
module tb_raccoon_ctrl;

  localparam int GW = 32;
  localparam int GH = 32;
  localparam int NCOLS = 20;
  localparam int NROWS = 15;
  localparam int START_COL = 9;
  localparam int START_ROW = 14;
  localparam int NLIVES = 3;
  localparam int DFRAMES = 60;
  localparam int COOL = 8;

  logic clk;
  logic reset;
  raccoon_ctrl_if bus();

  raccoon_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  // Game model: grid cell, lives, score, mode (0 play, 1 dying, 2 over),
  // tick of the last accepted move / restart, and tick at which dying ends.
  int t;
  int m_col;
  int m_row;
  int m_lives;
  int m_score;
  int m_mode;
  int m_lock;
  int m_dend;

  typedef struct {
    int         n;
    logic [3:0] btn;
    int         c2x;
    int         c2y;
    int         ex;
    int         ey;
    int         el;
    int         es;
    int         ed;
    int         eg;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, t);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_x"}, int'(bus.raccoonX), m_col * GW);
    chk({tag, "_y"}, int'(bus.raccoonY), m_row * GH);
    chk({tag, "_lives"}, int'(bus.lives), m_lives);
    chk({tag, "_score"}, int'(bus.score), m_score);
    chk({tag, "_dead"}, int'(bus.dead), (m_mode == 1) ? 1 : 0);
    chk({tag, "_game_over"}, int'(bus.game_over), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_col   = START_COL;
    m_row   = START_ROW;
    m_lives = NLIVES;
    m_score = 0;
    m_mode  = 0;
    m_lock  = t - 1000;
    m_dend  = 0;
  endtask

  function automatic bit overlaps(input int rx, input int ry, input int cx, input int cy);
    return (rx < cx + 64) && (cx < rx + GW) && (ry < cy + 32) && (cy < ry + GH);
  endfunction

  task automatic model_step(input logic [3:0] b);
    int rx;
    int ry;
    int nc;
    int nr;
    bit hit;
    t++;
    rx = m_col * GW;
    ry = m_row * GH;
    if (m_mode == 0) begin
      hit = overlaps(rx, ry, int'(bus.carX_1), int'(bus.carY_1)) ||
            overlaps(rx, ry, int'(bus.carX_2), int'(bus.carY_2)) ||
            overlaps(rx, ry, int'(bus.carX_3), int'(bus.carY_3));
      if (hit) begin
        m_mode  = 1;
        m_lives = m_lives - 1;
        m_dend  = t + DFRAMES;
      end else if ((t - m_lock >= COOL) && (b != 4'b0000)) begin
        nc = m_col;
        nr = m_row;
        if (b[3]) nr = nr - 1;
        else if (b[2]) nr = nr + 1;
        else if (b[1]) nc = nc - 1;
        else nc = nc + 1;
        if (nc >= 0 && nc < NCOLS && nr >= 0 && nr < NROWS) begin
          m_lock = t;
          if (nr == 0) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_col = START_COL;
            m_row = START_ROW;
          end else begin
            m_col = nc;
            m_row = nr;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (t == m_dend) begin
        if (m_lives == 0) begin
          m_mode = 2;
        end else begin
          m_mode = 0;
          m_col  = START_COL;
          m_row  = START_ROW;
          m_lock = t - 1000;
        end
      end
    end else begin
      if (b != 4'b0000) begin
        m_mode  = 0;
        m_lives = NLIVES;
        m_score = 0;
        m_col   = START_COL;
        m_row   = START_ROW;
        m_lock  = t;
      end
    end
  endtask

  // One frame tick with buttons {up, down, left, right}; outputs checked a cycle later.
  task automatic tick(input logic [3:0] b);
    @(negedge clk);
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
    bus.frame_tick = 1'b1;
    model_step(b);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check_model("tick");
  endtask

  task automatic set_cars(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3);
    bus.carX_1 = 10'(x1);
    bus.carY_1 = 10'(y1);
    bus.carX_2 = 10'(x2);
    bus.carY_2 = 10'(y2);
    bus.carX_3 = 10'(x3);
    bus.carY_3 = 10'(y3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int clamp10(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    t = 0;
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    set_cars(0, 0, 0, 0, 0, 0);

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_x", int'(bus.raccoonX), 288);
    chk("rst_y", int'(bus.raccoonY), 448);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_dead", int'(bus.dead), 0);
    chk("rst_game_over", int'(bus.game_over), 0);
    @(negedge clk);
    reset = 1'b0;

    // Table: {ticks, buttons, car2 x/y, expected x, y, lives, score, dead, game_over}.
    vecs[0] = '{1,  4'b1000, 0,   0,   288, 416, 3, 0, 0, 0};
    vecs[1] = '{7,  4'b0100, 0,   0,   288, 416, 3, 0, 0, 0};
    vecs[2] = '{1,  4'b0100, 0,   0,   288, 448, 3, 0, 0, 0};
    vecs[3] = '{8,  4'b1010, 0,   0,   288, 416, 3, 0, 0, 0};
    vecs[4] = '{1,  4'b0001, 288, 416, 288, 416, 2, 0, 1, 0};
    vecs[5] = '{59, 4'b0000, 0,   0,   288, 416, 2, 0, 1, 0};
    vecs[6] = '{1,  4'b0000, 0,   0,   288, 448, 2, 0, 0, 0};
    vecs[7] = '{1,  4'b0100, 0,   0,   288, 448, 2, 0, 0, 0};
    vecs[8] = '{1,  4'b1000, 0,   0,   288, 416, 2, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      bus.carX_2 = 10'(vecs[i].c2x);
      bus.carY_2 = 10'(vecs[i].c2y);
      for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].btn);
      chk($sformatf("vec%0d_x", i), int'(bus.raccoonX), vecs[i].ex);
      chk($sformatf("vec%0d_y", i), int'(bus.raccoonY), vecs[i].ey);
      chk($sformatf("vec%0d_lives", i), int'(bus.lives), vecs[i].el);
      chk($sformatf("vec%0d_score", i), int'(bus.score), vecs[i].es);
      chk($sformatf("vec%0d_dead", i), int'(bus.dead), vecs[i].ed);
      chk($sformatf("vec%0d_game_over", i), int'(bus.game_over), vecs[i].eg);
    end

    // Reset halfway through dying (death counter at 30).
    bus.carX_2 = 10'd288;
    bus.carY_2 = 10'd416;
    tick(4'b0000);
    bus.carX_2 = 10'd0;
    bus.carY_2 = 10'd0;
    for (int k = 0; k < 30; k++) tick(4'b0000);
    chk("middie_dead_before", int'(bus.dead), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("middie_dead", int'(bus.dead), 0);
    chk("middie_lives", int'(bus.lives), 3);
    check_model("middie");
    @(negedge clk);
    reset = 1'b0;
    tick(4'b1000);
    chk("middie_up_y", int'(bus.raccoonY), 416);

    // Crossing: up held, the 14th move scores and returns home.
    do_reset();
    for (int k = 0; k < 104; k++) tick(4'b1000);
    chk("cross_pre_y", int'(bus.raccoonY), 32);
    chk("cross_pre_score", int'(bus.score), 0);
    tick(4'b1000);
    chk("cross_y", int'(bus.raccoonY), 448);
    chk("cross_x", int'(bus.raccoonX), 288);
    chk("cross_score", int'(bus.score), 1);

    // Left edge: blocked left does not load cooldown; right accepted next tick.
    do_reset();
    for (int k = 0; k < 65; k++) tick(4'b0010);
    chk("left_edge_x", int'(bus.raccoonX), 0);
    for (int k = 0; k < 8; k++) tick(4'b0010);
    chk("left_hold_x", int'(bus.raccoonX), 0);
    tick(4'b0001);
    chk("right_after_edge_x", int'(bus.raccoonX), 32);
    for (int k = 0; k < 150; k++) tick(4'b0001);
    chk("right_edge_x", int'(bus.raccoonX), 608);
    for (int k = 0; k < 9; k++) tick(4'b0001);
    chk("right_hold_x", int'(bus.raccoonX), 608);

    // Three hits lead to game over; any button restarts without moving.
    do_reset();
    bus.carX_2 = 10'd256;
    bus.carY_2 = 10'd448;
    for (int d = 0; d < 3; d++) begin
      tick(4'b0000);
      chk("hit_dead", int'(bus.dead), 1);
      for (int k = 0; k < DFRAMES; k++) tick(4'b0000);
    end
    chk("go_flag", int'(bus.game_over), 1);
    chk("go_lives", int'(bus.lives), 0);
    chk("go_dead", int'(bus.dead), 0);
    bus.carX_2 = 10'd0;
    bus.carY_2 = 10'd0;
    tick(4'b0010);
    chk("restart_lives", int'(bus.lives), 3);
    chk("restart_score", int'(bus.score), 0);
    chk("restart_x", int'(bus.raccoonX), 288);
    chk("restart_go", int'(bus.game_over), 0);
    tick(4'b0010);
    chk("restart_nomove_x", int'(bus.raccoonX), 288);

    // Randomized play against the model, with idle cycles between ticks.
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      int rx;
      int ry;
      int gap;
      logic [3:0] b;
      rx = m_col * GW;
      ry = m_row * GH;
      bus.carX_1 = 10'($urandom_range(0, 1023));
      bus.carY_1 = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 59) == 0) begin
        bus.carX_2 = 10'(clamp10(rx + int'($urandom_range(0, 95)) - 64));
        bus.carY_2 = 10'(ry);
      end else begin
        bus.carX_2 = 10'($urandom_range(0, 1023));
        bus.carY_2 = 10'($urandom_range(0, 1023));
      end
      bus.carX_3 = 10'($urandom_range(0, 1023));
      bus.carY_3 = 10'($urandom_range(0, 1023));
      b = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(1, 15));
      tick(b);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        bus.carX_2 = 10'(rx);
        bus.carY_2 = 10'(ry);
        repeat (gap) @(negedge clk);
        check_model("idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
